term_write_arbiter: RTL and testbench
=====================================

# term_write_arbiter

Sequences and shares the VGA terminal's single character-write port between two requesters: the keyboard ASCII FIFO stream and a host (CPU/SPI) write port. For the keyboard stream it owns the text cursor, interprets control codes (newline, backspace, arrows), pops the FIFO, and issues character writes. Host writes go to explicit addresses and never move the cursor. The block sits between the ASCII keyboard front end and the VGA terminal, replacing ad-hoc cursor logic in top-level demos.

## Interface

- COLS, 80, characters per row
- ROWS, 60, rows per screen
- ADDR_WIDTH, 13, terminal address width; must satisfy 2^ADDR_WIDTH >= COLS*ROWS
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- kb_valid  in  1  keyboard FIFO non-empty
- kb_ascii  in  8  keyboard FIFO head byte
- kb_next  out  1  one-cycle FIFO pop strobe
- host_req  in  1  host write request, level; held until host_grant
- host_addr  in  ADDR_WIDTH  host target address
- host_data  in  8  host character
- host_grant  out  1  one-cycle acknowledge; host may change or drop its request next cycle
- host_err  out  1  sticky: host request with host_addr >= COLS*ROWS was seen
- term_busy  in  1  terminal cannot accept a write
- term_cs  out  1  one-cycle write strobe to terminal
- term_address  out  ADDR_WIDTH  write address, valid while term_cs is high
- term_data  out  8  write data, valid while term_cs is high
- cursor  out  ADDR_WIDTH  current keyboard cursor position

## Operation

- Reset values: all outputs 0, cursor 0, FSM in IDLE, round-robin pointer favours the keyboard.
- FSM states: IDLE, KB_DECODE, ISSUE, GAP.
- IDLE, entered only with term_busy=0, arbitrates between kb_valid and host_req.
  - If only one requester is active, it wins.
  - If both are active, the requester not granted last time wins (round robin).
  - If term_busy=1, IDLE waits and grants nothing.
- Keyboard win: pulse kb_next, latch kb_ascii, go to KB_DECODE.
- KB_DECODE acts on the latched byte. Let L = COLS*ROWS.
  - 0xEB (left): cursor-1.
  - 0xF4 (right): cursor+1.
  - 0xF5 (up): cursor-COLS.
  - 0xF2 (down): cursor+COLS.
  - All four arrows update the cursor with no terminal write, then go to IDLE.
  - 0x0A (newline): cursor = start of next row, no write, go to IDLE.
  - 0xF7 (backspace): cursor-1, then write 0x20 at the new cursor.
  - 0xFF (unmapped): discarded, no write, go to IDLE.
  - Any other byte: write it at the cursor, go to ISSUE, then cursor+1 after the write.
- Cursor wrap rules (all arithmetic modulo L, never outside 0..L-1):
  - L-1 +1 goes to 0; 0 -1 goes to L-1.
  - Up from row 0 goes to the last row, same column.
  - Down from the last row goes to row 0, same column.
  - Newline on the last row goes to 0.
- Host win with host_addr < L: load term_address/term_data from the host, go to ISSUE.
- Host win with host_addr >= L: pulse host_grant, set host_err, no write, return to IDLE.
- ISSUE: term_cs=1 for exactly one cycle.
  - A host transaction pulses host_grant in this same cycle.
  - A keyboard printable write updates the cursor in this same cycle.
  - Next state is GAP.
- GAP: one mandatory idle cycle, so the terminal can raise busy, then go to IDLE.
- host_err clears only on rst.

## Timing

- Keyboard printable: kb_next at cycle T, term_cs at T+2, cursor updates at the end of T+2, next arbitration no earlier than T+4.
- Keyboard control codes: kb_next at T, cursor updated at end of T+1, next arbitration at T+2.
- Host: request seen in IDLE at T, term_cs and host_grant at T+1, next arbitration at T+3.
- kb_next is never asserted when kb_valid=0.
- At most one of kb_next/host_grant is asserted per transaction.
- term_cs is never asserted while term_busy=1 was sampled in the arbitrating IDLE cycle.
- rst asserted mid-transaction aborts it immediately: no term_cs, no grant. A byte already popped is lost.

## Test plan

- Reset, then feed keyboard "a","b" with term_busy=0 -> term_cs writes 0x61@0 and 0x62@1; cursor=2; two kb_next pulses.
- cursor=0, keyboard 0xF7 -> term_cs writes 0x20@4799, cursor=4799; then 0xF4 -> cursor=0 with no term_cs.
- cursor=4790, keyboard 0x0A -> cursor=0; then 0xF5 -> cursor=4720; then 0xF2 -> cursor=0.
- kb_valid and host_req (addr 100, data 0x41) held continuously -> grants alternate keyboard, host, keyboard…; every term_cs is separated by at least 3 cycles.
- host_req with addr 5000 -> host_grant pulse, host_err=1, no term_cs; cursor unchanged.
- term_busy=1 held for 10 cycles with kb_valid=1 -> no kb_next and no term_cs until busy falls; then a normal write; rst in KB_DECODE -> all outputs 0, cursor 0.

Source files
------------

// File: rtl/term_write_arbiter.sv
// term_write_arbiter: shares the terminal write port between the keyboard stream (cursor owner) and host writes
module term_write_arbiter #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kb_valid,
  input  logic [7:0]            kb_ascii,
  output logic                  kb_next,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_data,
  output logic                  host_grant,
  output logic                  host_err,
  input  logic                  term_busy,
  output logic                  term_cs,
  output logic [ADDR_WIDTH-1:0] term_address,
  output logic [7:0]            term_data,
  output logic [ADDR_WIDTH-1:0] cursor
);
  localparam int W1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] CV   = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] TOP  = ADDR_WIDTH'(COLS * ROWS - COLS);
  localparam logic [W1-1:0]         LIM  = W1'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, KB_DECODE, ISSUE, GAP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cursor_q, cursor_d, addr_q, addr_d;
  logic [7:0]            data_q, data_d, byte_q, byte_d;
  logic                  host_txn_q, host_txn_d, adv_q, adv_d;
  logic                  prio_host_q, prio_host_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] inc, dec, up, down, nl;
  logic [W1-1:0]         nl_w;
  logic                  host_ok, kb_win;

  assign inc     = cursor_q == LAST ? '0 : cursor_q + 1'b1;
  assign dec     = cursor_q == '0 ? LAST : cursor_q - 1'b1;
  assign up      = cursor_q < CV ? cursor_q + TOP : cursor_q - CV;
  assign down    = cursor_q >= TOP ? cursor_q - TOP : cursor_q + CV;
  assign nl_w    = {1'b0, cursor_q - cursor_q % CV} + W1'(COLS);
  assign nl      = nl_w >= LIM ? '0 : nl_w[ADDR_WIDTH-1:0];
  assign host_ok = {1'b0, host_addr} < LIM;
  assign kb_win  = kb_valid && !(host_req && prio_host_q);

  assign term_address = addr_q;
  assign term_data    = data_q;
  assign cursor       = cursor_q;
  assign host_err     = err_q;

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    addr_d      = addr_q;
    data_d      = data_q;
    byte_d      = byte_q;
    host_txn_d  = host_txn_q;
    adv_d       = adv_q;
    prio_host_d = prio_host_q;
    err_d       = err_q;
    kb_next     = 1'b0;
    host_grant  = 1'b0;
    term_cs     = 1'b0;
    case (state_q)
      IDLE: begin
        // strobes are combinational here, so hold them off while reset is asserted
        if (!term_busy && !rst && kb_win) begin
          kb_next     = 1'b1;
          byte_d      = kb_ascii;
          prio_host_d = 1'b1;
          state_d     = KB_DECODE;
        end else if (!term_busy && !rst && host_req) begin
          prio_host_d = 1'b0;
          host_grant  = !host_ok;
          err_d       = err_q || !host_ok;
          addr_d      = host_ok ? host_addr : addr_q;
          data_d      = host_ok ? host_data : data_q;
          host_txn_d  = 1'b1;
          adv_d       = 1'b0;
          state_d     = host_ok ? ISSUE : IDLE;
        end
      end
      KB_DECODE: begin
        host_txn_d = 1'b0;
        adv_d      = 1'b0;
        state_d    = IDLE;
        case (byte_q)
          8'hEB: cursor_d = dec;
          8'hF4: cursor_d = inc;
          8'hF5: cursor_d = up;
          8'hF2: cursor_d = down;
          8'h0A: cursor_d = nl;
          8'hFF: state_d = IDLE;
          8'hF7: begin
            cursor_d = dec;
            addr_d   = dec;
            data_d   = 8'h20;
            state_d  = ISSUE;
          end
          default: begin
            addr_d  = cursor_q;
            data_d  = byte_q;
            adv_d   = 1'b1;
            state_d = ISSUE;
          end
        endcase
      end
      ISSUE: begin
        term_cs    = 1'b1;
        host_grant = host_txn_q;
        cursor_d   = adv_q ? inc : cursor_q;
        state_d    = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      byte_q      <= '0;
      host_txn_q  <= 1'b0;
      adv_q       <= 1'b0;
      prio_host_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      byte_q      <= byte_d;
      host_txn_q  <= host_txn_d;
      adv_q       <= adv_d;
      prio_host_q <= prio_host_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_term_write_arbiter.sv
// tb_term_write_arbiter: directed vectors and corner sequences for term_write_arbiter
module tb_term_write_arbiter;
  logic        clk = 0, rst = 1;
  logic        kb_valid = 0, host_req = 0, term_busy = 0;
  logic [7:0]  kb_ascii = 0, host_data = 0;
  logic [12:0] host_addr = 0;
  logic        kb_next, host_grant, host_err, term_cs;
  logic [12:0] term_address, cursor;
  logic [7:0]  term_data;

  term_write_arbiter dut (
    .clk(clk), .rst(rst), .kb_valid(kb_valid), .kb_ascii(kb_ascii), .kb_next(kb_next),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_grant(host_grant),
    .host_err(host_err), .term_busy(term_busy), .term_cs(term_cs), .term_address(term_address),
    .term_data(term_data), .cursor(cursor)
  );

  always #5 clk = ~clk;

  int cyc = 0, kbn_cnt = 0, hg_cnt = 0, cs_cnt = 0;
  int kbn_cyc = 0, hg_cyc = 0, cs_cyc = -100, kbn_bad = 0, sp_bad = 0;
  int last_addr = 0, last_data = 0;
  int order[$];

  always @(negedge clk) begin
    cyc++;
    if (kb_next) begin
      kbn_cnt++;
      kbn_cyc = cyc;
      order.push_back(0);
      if (!kb_valid) kbn_bad++;
    end
    if (host_grant) begin
      hg_cnt++;
      hg_cyc = cyc;
      order.push_back(1);
    end
    if (term_cs) begin
      if (cyc - cs_cyc < 3) sp_bad++;
      cs_cnt++;
      cs_cyc = cyc;
      last_addr = int'(term_address);
      last_data = int'(term_data);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic kb_txn(input logic [7:0] b);
    logic got = 0;
    kb_ascii = b;
    kb_valid = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = kb_next;
    end
    if (!got) chk("kb_next_timeout", 0, 1);
    @(posedge clk);
    #1 kb_valid = 0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic host_txn(input logic [12:0] a, input logic [7:0] d);
    logic got = 0;
    host_addr = a;
    host_data = d;
    host_req = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = host_grant;
    end
    if (!got) chk("host_grant_timeout", 0, 1);
    @(posedge clk);
    #1 host_req = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] b;
    int reps;
    int ncs;
    int addr;
    int data;
    int cur;
  } vec_t;

  vec_t tbl[16];
  int c0, k0, h0, n0;

  initial begin
    tbl = '{
      '{8'h61, 1, 1, 0, 8'h61, 1},
      '{8'h62, 1, 1, 1, 8'h62, 2},
      '{8'hEB, 2, 0, 0, 0, 0},
      '{8'hF7, 1, 1, 4799, 8'h20, 4799},
      '{8'hF4, 1, 0, 0, 0, 0},
      '{8'hEB, 10, 0, 0, 0, 4790},
      '{8'h0A, 1, 0, 0, 0, 0},
      '{8'hF5, 1, 0, 0, 0, 4720},
      '{8'hF2, 1, 0, 0, 0, 0},
      '{8'hF2, 1, 0, 0, 0, 80},
      '{8'h0A, 1, 0, 0, 0, 160},
      '{8'h63, 1, 1, 160, 8'h63, 161},
      '{8'hFF, 1, 0, 0, 0, 161},
      '{8'hF5, 1, 0, 0, 0, 81},
      '{8'hF4, 1, 0, 0, 0, 82},
      '{8'hF7, 1, 1, 81, 8'h20, 81}
    };
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_cs", int'(term_cs), 0);
    chk("rst_kb_next", int'(kb_next), 0);
    chk("rst_grant", int'(host_grant), 0);
    chk("rst_err", int'(host_err), 0);
    chk("rst_addr", int'(term_address), 0);
    chk("rst_data", int'(term_data), 0);
    @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 16; i++) begin
      c0 = cs_cnt;
      k0 = kbn_cnt;
      for (int r = 0; r < tbl[i].reps; r++) kb_txn(tbl[i].b);
      chk($sformatf("v%0d_cursor", i), int'(cursor), tbl[i].cur);
      chk($sformatf("v%0d_ncs", i), cs_cnt - c0, tbl[i].ncs);
      chk($sformatf("v%0d_pops", i), kbn_cnt - k0, tbl[i].reps);
      if (tbl[i].ncs > 0) begin
        chk($sformatf("v%0d_addr", i), last_addr, tbl[i].addr);
        chk($sformatf("v%0d_data", i), last_data, tbl[i].data);
        chk($sformatf("v%0d_latency", i), cs_cyc - kbn_cyc, 2);
      end
    end

    c0 = cs_cnt;
    h0 = hg_cnt;
    host_txn(13'd100, 8'h41);
    chk("host_ncs", cs_cnt - c0, 1);
    chk("host_grants", hg_cnt - h0, 1);
    chk("host_addr", last_addr, 100);
    chk("host_data", last_data, 8'h41);
    chk("host_grant_with_cs", hg_cyc, cs_cyc);
    chk("host_cursor", int'(cursor), 81);
    chk("host_err_clean", int'(host_err), 0);

    c0 = cs_cnt;
    h0 = hg_cnt;
    host_txn(13'd5000, 8'h42);
    chk("bad_host_ncs", cs_cnt - c0, 0);
    chk("bad_host_grants", hg_cnt - h0, 1);
    chk("bad_host_err", int'(host_err), 1);
    chk("bad_host_cursor", int'(cursor), 81);

    do_reset();
    chk("err_cleared", int'(host_err), 0);
    n0 = order.size();
    c0 = cs_cnt;
    kb_ascii = 8'h78;
    kb_valid = 1;
    host_addr = 13'd100;
    host_data = 8'h41;
    host_req = 1;
    repeat (30) @(posedge clk);
    #1 kb_valid = 0;
    host_req = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("rr_enough", int'(order.size() - n0 >= 6), 1);
    for (int i = 0; i < 6 && n0 + i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), order[n0 + i], i % 2);
    chk("rr_cs_per_grant", cs_cnt - c0, order.size() - n0);

    do_reset();
    c0 = cs_cnt;
    k0 = kbn_cnt;
    term_busy = 1;
    kb_ascii = 8'h7A;
    kb_valid = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_pops", kbn_cnt - k0, 0);
    chk("busy_ncs", cs_cnt - c0, 0);
    term_busy = 0;
    kb_txn(8'h7A);
    chk("busy_after_ncs", cs_cnt - c0, 1);
    chk("busy_after_addr", last_addr, 0);
    chk("busy_after_data", last_data, 8'h7A);
    chk("busy_after_cursor", int'(cursor), 1);

    begin
      logic got = 0;
      kb_ascii = 8'h71;
      kb_valid = 1;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = kb_next;
      end
      if (!got) chk("abort_kb_next_timeout", 0, 1);
    end
    c0 = cs_cnt;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("abort_cs", int'(term_cs), 0);
    chk("abort_kb_next", int'(kb_next), 0);
    chk("abort_grant", int'(host_grant), 0);
    chk("abort_cursor", int'(cursor), 0);
    chk("abort_addr", int'(term_address), 0);
    chk("abort_data", int'(term_data), 0);
    kb_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_write", cs_cnt - c0, 0);

    chk("kb_next_without_valid", kbn_bad, 0);
    chk("cs_spacing", sp_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end
endmodule
